// File: rtl/reqack_responder.sv
// Target-side request/acknowledge responder: runs the ACK -> DATA -> DONE handshake
// for every request and buffers requests that arrive mid-handshake in a small FIFO.
module reqack_responder #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         request,
   input  logic [DW-1:0]                data_in,
   output logic                         acknowledge,
   output logic                         data_enable,
   output logic [DW-1:0]                data_out,
   output logic                         done,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   pending,
   output logic                         overflow,
   output logic [CNT_W-1:0]             xfer_count
);

   localparam int PW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ACK, DATA, DONE} state_t;

   state_t          state, state_nx;
   logic [DW-1:0]   xfer_q;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [PW-1:0]   count;

   logic fifo_empty, fifo_full, in_flight;
   logic pop, push, drop, load;
   logic [DW-1:0] load_data;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
   endfunction

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == PW'(DEPTH));
   assign in_flight  = (state == ACK) || (state == DATA);

   // In DONE a pop frees a slot, so a simultaneous push is always accepted.
   assign pop       = (state == DONE) && !fifo_empty;
   assign push      = request && ((in_flight && !fifo_full) || pop);
   assign drop      = request && in_flight && fifo_full;
   assign load      = ((state == IDLE) && request) || ((state == DONE) && (pop || request));
   assign load_data = pop ? mem[rd_ptr] : data_in;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = request ? ACK : IDLE;
         ACK:  state_nx = DATA;
         DATA: state_nx = DONE;
         DONE: state_nx = (pop || request) ? ACK : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      acknowledge = (state == ACK);
      data_enable = (state == DATA);
      done        = (state == DONE);
      busy        = (state != IDLE);
      data_out    = (state == DATA) ? xfer_q : '0;
   end

   always_ff @(posedge clk) begin
      if (rst)       xfer_q <= '0;
      else if (load) xfer_q <= load_data;
   end

   // Storage array carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         xfer_count <= '0;
      end else begin
         if (drop) overflow <= 1'b1;
         if (state == DONE) xfer_count <= xfer_count + CNT_W'(1);
      end
   end

   assign pending = count;

endmodule

// File: doc/reqack_responder.md
Name: reqack_responder

Overview:
- Target-side handshake controller that generates acknowledge, data_enable and done in response to request. It directly drives the signals checked by the handshake assertion `request |=> acknowledge ##1 data_enable ##1 done`.
- Captures a data word per request and presents it on data_out during the data_enable cycle.
- Requests arriving while a handshake is in flight are buffered in a small FIFO and serviced back-to-back.

Parameters:
- DW, 8, width of data_in/data_out.
- DEPTH, 4, pending-request FIFO depth (>=1).
- CNT_W, 16, width of completed-transfer counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- request  in  1  upstream request, sampled every posedge clk
- data_in  in  DW  payload, sampled in the same cycle as request
- acknowledge  out  1  high exactly one cycle, first cycle of a handshake
- data_enable  out  1  high exactly one cycle, cycle after acknowledge
- data_out  out  DW  payload of the current handshake; valid only while data_enable=1, otherwise 0
- done  out  1  high exactly one cycle, cycle after data_enable
- busy  out  1  1 in any non-IDLE state
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky; set when a request is dropped on a full FIFO; cleared only by rst
- xfer_count  out  CNT_W  number of completed handshakes (done cycles); wraps modulo 2^CNT_W

Behaviour:
- State machine states: IDLE, ACK, DATA, DONE.
- All outputs are registered or decoded from state only; there is no combinational path from request to any output.
- Reset (rst=1 at posedge):
  - state=IDLE.
  - acknowledge=data_enable=done=busy=overflow=0.
  - data_out=0, pending=0, xfer_count=0.
  - FIFO emptied; the transfer register is cleared.
  - Reset mid-handshake aborts it: no done, no count increment.
- IDLE:
  - request=1: latch data_in into the transfer register, next=ACK. This gives acknowledge in cycle t+1, data_enable in t+2 and done in t+3 for a request sampled at edge t.
  - request=0: stay in IDLE.
- ACK -> DATA -> DONE unconditionally, one cycle each.
  - acknowledge=1 in ACK.
  - data_enable=1 and data_out=transfer register in DATA.
  - done=1 in DONE.
- Request sampled in ACK or DATA:
  - push data_in into the FIFO.
  - If the FIFO is full, drop the request and set overflow=1.
- DONE, evaluated at the edge ending the DONE cycle:
  - FIFO non-empty: pop the head into the transfer register, next=ACK. A simultaneous request pushes data_in; this push is allowed even when the FIFO is full, because the pop frees a slot.
  - FIFO empty and request=1: bypass, latch data_in directly, next=ACK.
  - Otherwise: next=IDLE.
- Back-to-back handshakes therefore have a period of 3 cycles, with no idle cycle between done and the next acknowledge.
- xfer_count increments by 1 on every cycle with done=1 and wraps from all-ones to 0.
- pending reflects occupancy after the edge's push/pop and never exceeds DEPTH.
- FIFO ordering is strict FIFO, and buffered requests are served before any new bypass request.
- Protocol contract:
  - The handshake assertion is guaranteed only for requests sampled in IDLE, or in DONE with the FIFO empty.
  - A requester that must satisfy the assertion for every request shall keep request low while busy=1.

Test Plan:
- Reset, then a single request with data_in=8'hA5 at edge 0 -> acknowledge@1, data_enable@2 with data_out=A5, done@3, busy low @4, xfer_count=1, handshake assertion passes.
- Request held high continuously for 9 cycles with data 01..09, FIFO DEPTH=4 -> handshakes at 3-cycle period, no gap.
  - Served order: 01, then queued 02 and 03, then later words.
  - The FIFO fills, overflow sets on the first dropped push, and pending never exceeds 4.
- Single request in IDLE (11), then requests during ACK (22) and DATA (33) -> pending=2 during DONE.
  - Following handshakes output 22 then 33 back-to-back.
  - done pulses total 3, xfer_count=3.
- FIFO full (pending=4) and request asserted in DONE -> pop and push in the same edge: pending stays 4 and overflow stays 0.
- rst asserted during DATA -> next cycle all outputs 0, no done, xfer_count unchanged from 0, next request handled normally with 3-cycle latency.
- Preload xfer_count to 16'hFFFF by 65535 handshakes (or CNT_W=4 build with 15) -> the next done wraps xfer_count to 0.
